// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 3x4 keypad scanner: FSM state encoding, the
// codes for the two non-digit keys, the row/column to key-code map and a
// helper that turns a key code into the one-hot digit vector.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        StScan     = 2'd0,
        StDebounce = 2'd1,
        StHeld     = 2'd2,
        StRelease  = 2'd3
    } state_e;

    localparam logic [3:0] KeyStar = 4'd10;
    localparam logic [3:0] KeyHash = 4'd11;

    // Nibble (row*3 + col) holds the code of the key at that crossing.
    localparam logic [47:0] KeyMapTable = {
        KeyHash, 4'd0, KeyStar,  // row 3
        4'd9,    4'd8, 4'd7,     // row 2
        4'd6,    4'd5, 4'd4,     // row 1
        4'd3,    4'd2, 4'd1      // row 0
    };

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [7:0] base;
        base = {(6'(row) * 6'd3 + 6'(col)), 2'b00};
        return KeyMapTable[base +: 4];
    endfunction

    // '*' and '#' are not digits, so they light no keypad bit.
    function automatic logic [9:0] keypad_onehot(input logic [3:0] code);
        logic [9:0] vec;
        vec = '0;
        if (code < 4'd10) begin
            vec[code] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan tick generator.
// Ports:
//   clk    - system clock
//   resetn - asynchronous active-low reset
//   tick   - one-cycle pulse every SCAN_DIV cycles (when the count wraps)
module keypad_tick_gen #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam logic [15:0] CountLast = 16'(SCAN_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CountLast);
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 3-column x 4-row matrix keypad scanner with debounce on press and release.
// Ports:
//   clk       - system clock
//   resetn    - asynchronous active-low reset
//   rows_n    - row sense lines, active-low, asynchronous to clk
//   cols_n    - column drive, active-low, exactly one column low
//   keypad    - one-hot digit vector of the accepted key (0 for '*' / '#')
//   key_code  - code of the accepted key (0-9, 10 = '*', 11 = '#')
//   key_valid - one-cycle pulse when a new press is accepted
//   key_held  - high from press acceptance until release is accepted
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] rows_n,
    output logic [2:0] cols_n,
    output logic [9:0] keypad,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] DebN = 4'(DEBOUNCE_N);

    logic       tick;
    logic [3:0] rows_meta_q, rows_s_q;
    state_e     state_q, state_d;
    logic [1:0] col_q, col_d;
    logic [1:0] row_q, row_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] keypad_q, keypad_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_held_q, key_held_d;

    logic [2:0] n_low;
    logic [1:0] low_idx;
    logic [1:0] col_next;
    logic [3:0] cnt_inc;
    logic       row_low;
    logic       load_key;
    logic       drop_key;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .resetn(resetn),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rows_meta_q <= 4'b1111;
            rows_s_q    <= 4'b1111;
        end else begin
            rows_meta_q <= rows_n;
            rows_s_q    <= rows_meta_q;
        end
    end

    always_comb begin
        n_low   = 3'd0;
        low_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!rows_s_q[i]) begin
                n_low   = n_low + 3'd1;
                low_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        keypad_d    = keypad_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        load_key    = 1'b0;
        drop_key    = 1'b0;

        col_next = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        row_low  = ~rows_s_q[row_q];

        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (n_low == 3'd1) begin
                        row_d = low_idx;
                        cnt_d = 4'd1;
                        if (DebN == 4'd1) begin
                            load_key = 1'b1;
                        end else begin
                            state_d = StDebounce;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                StDebounce: begin
                    // Only the captured row may be low; anything else restarts the scan.
                    if (rows_s_q == ~(4'b0001 << row_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebN) begin
                            load_key = 1'b1;
                        end
                    end else begin
                        state_d = StScan;
                        col_d   = col_next;
                        cnt_d   = 4'd0;
                    end
                end
                StHeld: begin
                    if (!row_low) begin
                        cnt_d = 4'd1;
                        if (DebN == 4'd1) begin
                            drop_key = 1'b1;
                        end else begin
                            state_d = StRelease;
                        end
                    end
                end
                StRelease: begin
                    if (!row_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebN) begin
                            drop_key = 1'b1;
                        end
                    end else begin
                        // Release bounced back: the key is still down, no new report.
                        state_d = StHeld;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = StScan;
                end
            endcase
        end

        if (load_key) begin
            state_d     = StHeld;
            key_code_d  = key_map(row_d, col_q);
            keypad_d    = keypad_onehot(key_map(row_d, col_q));
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
        end

        if (drop_key) begin
            state_d    = StScan;
            keypad_d   = '0;
            key_code_d = 4'd0;
            key_held_d = 1'b0;
            col_d      = col_next;
            cnt_d      = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StScan;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            cnt_q       <= 4'd0;
            keypad_q    <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            keypad_q    <= keypad_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign cols_n    = ~(3'b001 << col_q);
    assign keypad    = keypad_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV = 4, DEBOUNCE_N = 3).
// A physical keypad model turns the pressed-key matrix and cols_n into rows_n.
// Stimulus pushes expected press/release events; a monitor pops and compares.
module tb_keypad_scanner;

    localparam int unsigned ScanDiv   = 4;
    localparam int unsigned DebounceN = 3;
    localparam int PressBound = 2 + 3 * ScanDiv + (DebounceN - 1) * ScanDiv + 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] rows_n;
    logic [2:0] cols_n;
    logic [9:0] keypad;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    bit pressed [4][3];

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         rel;
        logic [3:0] code;
    } ev_t;
    ev_t exp_q[$];

    keypad_scanner #(
        .SCAN_DIV  (ScanDiv),
        .DEBOUNCE_N(DebounceN)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rows_n   (rows_n),
        .cols_n   (cols_n),
        .keypad   (keypad),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column; the row reads low when that column is driven.
    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r][c] && !cols_n[c]) rows_n[r] = 1'b0;
            end
        end
    end

    // Keypad layout: rows 0-2 hold digits 1-9 left to right, row 3 is '*', '0', '#'.
    function automatic logic [3:0] ref_code(input int r, input int c);
        if (r < 3) return 4'(r * 3 + c + 1);
        if (c == 1) return 4'd0;
        return (c == 0) ? 4'd10 : 4'd11;
    endfunction

    function automatic logic [9:0] ref_keypad(input logic [3:0] code);
        logic [9:0] v;
        v = '0;
        for (int d = 0; d < 10; d++) if (code == 4'(d)) v = 10'(1) << d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted press and release against the scoreboard.
    bit prev_valid = 1'b0;
    bit prev_held  = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_valid <= 1'b0;
            prev_held  <= 1'b0;
        end else begin
            check("cols_one_low", $countones(~cols_n), 1);
            if (key_valid) begin
                check("valid_single_cycle", 32'(prev_valid), 0);
                check("pending_press_event", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("event_is_press", 32'(ev.rel), 0);
                    check("key_code", 32'(key_code), 32'(ev.code));
                    check("keypad", 32'(keypad), 32'(ref_keypad(ev.code)));
                    check("key_held_on_valid", 32'(key_held), 1);
                end
            end
            if (prev_held && !key_held) begin
                check("pending_release_event", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("event_is_release", 32'(ev.rel), 1);
                    check("keypad_cleared", 32'(keypad), 0);
                    check("key_code_cleared", 32'(key_code), 0);
                end
            end
            prev_valid <= key_valid;
            prev_held  <= key_held;
        end
    end

    task automatic press(input int r, input int c);
        int  n = 0;
        bit  seen = 1'b0;
        logic [3:0] code;
        code = ref_code(r, c);
        pressed[r][c] = 1'b1;
        exp_q.push_back('{rel: 1'b0, code: code});
        for (int i = 1; i <= PressBound && !seen; i++) begin
            @(negedge clk);
            if (key_valid) begin
                seen = 1'b1;
                n = i;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL press_latency: no key_valid within %0d cycles for code %0d",
                     PressBound, code);
        end
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 3; c++) pressed[r][c] = 1'b0;
    endtask

    // Release must be accepted on the third tick after the synchronised row goes high.
    task automatic release_all();
        int n = 0;
        bit done = 1'b0;
        exp_q.push_back('{rel: 1'b1, code: 4'd0});
        clear_keys();
        for (int i = 1; i <= 24 && !done; i++) begin
            @(negedge clk);
            if (!key_held) begin
                done = 1'b1;
                n = i;
            end
        end
        checks++;
        if (!(done && n >= 11 && n <= 14)) begin
            errors++;
            $display("FAIL release_latency: got %0d cycles expected 11..14", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cols_n"}, 32'(cols_n), 32'(3'b110));
        check({tag, "_keypad"}, 32'(keypad), 0);
        check({tag, "_key_code"}, 32'(key_code), 0);
        check({tag, "_key_valid"}, 32'(key_valid), 0);
        check({tag, "_key_held"}, 32'(key_held), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [2:0] cols_seen;
        int r, c;

        clear_keys();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // '5': hold, then release.
        press(1, 1);
        repeat (40) @(negedge clk);
        check("held5_key_code", 32'(key_code), 5);
        check("held5_keypad", 32'(keypad), 32'(10'b0000100000));
        release_all();
        repeat (8) @(negedge clk);

        // Bouncing contact: never stable long enough, columns must keep rotating.
        for (int k = 0; k < 3; k++) begin
            pressed[1][1] = 1'b1;
            repeat (ScanDiv) @(negedge clk);
            pressed[1][1] = 1'b0;
            repeat (ScanDiv) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        cols_seen = '0;
        for (int k = 0; k < 4 * ScanDiv; k++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) if (!cols_n[j]) cols_seen[j] = 1'b1;
        end
        check("bounce_cols_rotate", 32'(cols_seen), 32'(3'b111));

        // '#': non-digit key lights no keypad bit.
        press(3, 2);
        repeat (20) @(negedge clk);
        release_all();
        repeat (8) @(negedge clk);

        // '1' and '4' share column 0: two rows low together must be ignored.
        pressed[0][0] = 1'b1;
        pressed[1][0] = 1'b1;
        repeat (40) @(negedge clk);
        check("multi_row_no_held", 32'(key_held), 0);
        clear_keys();
        repeat (8) @(negedge clk);

        // '7' held, then '3' added: no second report.
        press(2, 0);
        repeat (10) @(negedge clk);
        pressed[0][2] = 1'b1;
        repeat (30) @(negedge clk);
        check("second_key_code_stays", 32'(key_code), 7);
        release_all();
        repeat (8) @(negedge clk);

        // Reset while '0' is held, then re-detection after reset.
        press(3, 1);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("midpress");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        press(3, 1);
        check("redetect_keypad", 32'(keypad), 32'(10'b0000000001));
        repeat (15) @(negedge clk);
        release_all();
        repeat (8) @(negedge clk);

        // Random single-key sessions.
        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(3, 0);
            c = $urandom_range(2, 0);
            press(r, c);
            repeat ($urandom_range(50, 20)) @(negedge clk);
            release_all();
            repeat ($urandom_range(20, 4)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles per column dwell (scan tick period); legal range 2..65535.
REQ-002 Parameter DEBOUNCE_N, default 4, consecutive matching tick samples required to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 rows_n  input  4  matrix row lines, active-low, asynchronous to clk.
REQ-006 cols_n  output  3  matrix column drive, active-low, exactly one bit low at all times.
REQ-007 keypad  output  10  one-hot digit vector (bit d = digit d) feeding the oven timer entry; level, held while the key is accepted as pressed.
REQ-008 key_code  output  4  code of the accepted key: 0-9 digits, 10 = '*', 11 = '#'; held with keypad.
REQ-009 key_valid  output  1  single-cycle pulse on acceptance of a new press.
REQ-010 key_held  output  1  high from acceptance until the release is accepted.

Function
REQ-011 rows_n SHALL pass a 2-flop synchronizer; all decisions use the synchronized value rows_s.
REQ-012 Tick generator: counter 0..SCAN_DIV-1, tick asserted for one cycle when count = SCAN_DIV-1, free-running in all states.
REQ-013 Key map (row r, col c): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#.
REQ-014 States: SCAN, DEBOUNCE, HELD, RELEASE; all transitions occur only on tick.
REQ-015 SCAN: on tick sample rows_s; exactly one row low -> capture (row, current column), cnt = 1, go DEBOUNCE, column frozen; zero or multiple rows low -> advance column 0->1->2->0, stay SCAN.
REQ-016 DEBOUNCE: on tick, only the captured row low -> cnt+1; when cnt reaches DEBOUNCE_N, go HELD. Any other row pattern -> go SCAN, advance to next column, cnt = 0.
REQ-017 DEBOUNCE_N = 1 SHALL go directly from SCAN to HELD on the first qualifying sample.
REQ-018 Entry to HELD: key_code and keypad loaded in the same cycle as the transition; key_valid high in that one cycle; key_held set. Keys '*' and '#' drive keypad = 0.
REQ-019 HELD: captured row low on tick (other rows ignored) -> stay; captured row high -> go RELEASE, cnt = 1.
REQ-020 RELEASE: captured row high on tick -> cnt+1; at DEBOUNCE_N go SCAN, clear keypad, key_code and key_held, advance column. Captured row low -> back to HELD with no new key_valid.
REQ-021 A second key pressed while HELD or RELEASE SHALL NOT be reported; a new key is accepted only from SCAN.
REQ-022 Press acceptance latency from stable rows_n: at most 2 + 3*SCAN_DIV + (DEBOUNCE_N-1)*SCAN_DIV cycles.
REQ-023 Debounce counter 4 bits, saturating; tick counter 16 bits.

Reset
REQ-024 resetn low SHALL immediately force: state SCAN, column 0 (cols_n = 3'b110), keypad = 0, key_code = 0, key_valid = 0, key_held = 0, counters = 0, synchronizer flops = 4'b1111.
REQ-025 Reset mid-press SHALL discard the key; after release of reset the still-pressed key is re-detected from SCAN and reported with a fresh key_valid.

Structure
REQ-026 Shared microwave include file SHALL hold the state encodings, key codes 10/11 and the key-map table.
REQ-027 Tick generator SHALL be a separate sub-module keypad_tick_gen (parameter SCAN_DIV, ports clk, resetn, tick).

Verification (SCAN_DIV = 4, DEBOUNCE_N = 3)
REQ-028 Press '5' (row1 low when col1 driven), hold 40 cycles -> one key_valid pulse, keypad = 10'b0000100000, key_code = 5.
REQ-029 Release '5' -> keypad = 0, key_held = 0 exactly 3 ticks after rows_s goes high; no further key_valid.
REQ-030 Bounce: row low for 1 tick, high 1 tick, repeated 3 times -> no key_valid, scanner returns to SCAN and keeps rotating columns.
REQ-031 Press '#' -> key_valid, key_code = 11, keypad = 0; simultaneous rows 0 and 1 low in SCAN -> ignored, no key_valid.
REQ-032 While '7' held, press '3' -> no second key_valid, key_code stays 7; release both -> return to SCAN.
REQ-033 Assert resetn low while '0' held -> outputs cleared same cycle; deassert with '0' still pressed -> new key_valid, key_code = 0, keypad = 10'b0000000001.
